// File: rtl/micro_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module   : micro_pkg
//  Purpose  : Shared types and protocol constants for the micro_loader image
//             loader: FSM state encoding, byte ordering of the length field
//             and of each data word, and a byte-join helper.
//  Revision : 1.0  initial release
//------------------------------------------------------------------------------
package micro_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_HI  = 4'd1,
        LEN_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        WRITE   = 4'd5,
        RUN     = 4'd6,
        ERROR   = 4'd7
    } state_t;

    // The first byte on the wire is the most significant byte for both the
    // 16-bit length field and every 16-bit instruction word.
    localparam bit c_LEN_MSB_FIRST  = 1'b1;
    localparam bit c_DATA_MSB_FIRST = 1'b1;

    function automatic logic [15:0] join_bytes(input logic [7:0] first,
                                               input logic [7:0] second,
                                               input bit         msb_first);
        return msb_first ? {first, second} : {second, first};
    endfunction

endpackage
`default_nettype wire

// File: rtl/micro_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module   : micro_loader
//  Purpose  : Receives a byte-serial program image (16-bit word count N,
//             then N 16-bit words), writes it into the instruction RAM and
//             then releases the micro core, gating its PC in free-run or
//             single-step mode. Bad lengths and inter-byte silence longer
//             than TIMEOUT_CYCLES park the loader in a sticky error state.
//  Ports    : clk, rst                 clock, synchronous active-high reset
//             rx_data, rx_valid        received byte stream
//             start_load               begin (or restart) an image load
//             run_mode, step_req       free-run / single-step PC control
//             iram_wa/iram_wen/iram_din instruction RAM write port
//             mic_rst, pc_enable       micro core control
//             busy, loaded, err        status flags
//             word_count               words written by the last load
//  Revision : 1.0  initial release
//------------------------------------------------------------------------------
module micro_loader
    import micro_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int IRAM_ADDR_BITS = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    input  logic                      start_load,
    input  logic                      run_mode,
    input  logic                      step_req,
    output logic [IRAM_ADDR_BITS-1:0] iram_wa,
    output logic                      iram_wen,
    output logic [WIDTH-1:0]          iram_din,
    output logic                      mic_rst,
    output logic                      pc_enable,
    output logic                      busy,
    output logic                      loaded,
    output logic                      err,
    output logic [IRAM_ADDR_BITS:0]   word_count
);

    localparam int                c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]       c_DEPTH   = 17'(1) << IRAM_ADDR_BITS;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [7:0]                r_len_first;
    logic [15:0]               r_len;
    logic [7:0]                r_first;
    logic [WIDTH-1:0]          r_word;
    logic [7:0]                r_skid;
    logic                      r_skid_vld;
    logic [c_TO_W-1:0]         r_idle_cnt;
    logic [IRAM_ADDR_BITS:0]   r_word_count;
    logic                      r_step_q;
    logic                      r_run_mode_q;

    logic [15:0]               w_len_rx;
    logic                      w_len_bad;
    logic                      w_last_word;
    logic                      w_waiting;
    logic                      w_timeout;

    assign w_len_rx    = join_bytes(r_len_first, rx_data, c_LEN_MSB_FIRST);
    assign w_len_bad   = (w_len_rx == 16'd0) || ({1'b0, w_len_rx} > c_DEPTH);
    assign w_last_word = (17'(r_word_count) + 17'd1) == {1'b0, r_len};

    // A cycle counts as idle only in a byte-collecting state with nothing
    // consumed; a pending skid byte in DATA_HI is a consumed byte.
    assign w_waiting = (r_state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO})
                       && !rx_valid
                       && !((r_state == DATA_HI) && r_skid_vld);
    assign w_timeout = w_waiting && (r_idle_cnt == c_TO_LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start_load) w_state_next = LEN_HI;
            end
            LEN_HI: begin
                if (rx_valid)       w_state_next = LEN_LO;
                else if (w_timeout) w_state_next = ERROR;
            end
            LEN_LO: begin
                if (rx_valid)       w_state_next = w_len_bad ? ERROR : DATA_HI;
                else if (w_timeout) w_state_next = ERROR;
            end
            DATA_HI: begin
                // With a skid byte pending, a byte arriving now is already
                // the low half, so the word completes in this cycle.
                if (r_skid_vld)     w_state_next = rx_valid ? WRITE : DATA_LO;
                else if (rx_valid)  w_state_next = DATA_LO;
                else if (w_timeout) w_state_next = ERROR;
            end
            DATA_LO: begin
                if (rx_valid)       w_state_next = WRITE;
                else if (w_timeout) w_state_next = ERROR;
            end
            WRITE: begin
                w_state_next = w_last_word ? RUN : DATA_HI;
            end
            RUN, ERROR: begin
                if (start_load) w_state_next = LEN_HI;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_len_first  <= '0;
            r_len        <= '0;
            r_first      <= '0;
            r_word       <= '0;
            r_skid       <= '0;
            r_skid_vld   <= 1'b0;
            r_idle_cnt   <= '0;
            r_word_count <= '0;
            r_step_q     <= 1'b0;
            r_run_mode_q <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_step_q     <= step_req;
            r_run_mode_q <= run_mode;
            r_idle_cnt   <= w_waiting ? r_idle_cnt + 1'b1 : '0;

            case (r_state)
                IDLE, RUN, ERROR: begin
                    if (start_load) begin
                        r_word_count <= '0;
                        r_skid_vld   <= 1'b0;
                    end
                end
                LEN_HI: begin
                    if (rx_valid) r_len_first <= rx_data;
                end
                LEN_LO: begin
                    if (rx_valid) r_len <= w_len_rx;
                end
                DATA_HI: begin
                    if (r_skid_vld) begin
                        r_skid_vld <= 1'b0;
                        if (rx_valid) r_word  <= join_bytes(r_skid, rx_data, c_DATA_MSB_FIRST);
                        else          r_first <= r_skid;
                    end else if (rx_valid) begin
                        r_first <= rx_data;
                    end
                end
                DATA_LO: begin
                    if (rx_valid) r_word <= join_bytes(r_first, rx_data, c_DATA_MSB_FIRST);
                end
                WRITE: begin
                    r_word_count <= r_word_count + 1'b1;
                    if (rx_valid && !w_last_word) begin
                        r_skid     <= rx_data;
                        r_skid_vld <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The word index of the write in flight equals the count before increment.
    assign iram_wa    = r_word_count[IRAM_ADDR_BITS-1:0];
    assign iram_wen   = (r_state == WRITE);
    assign iram_din   = r_word;
    assign mic_rst    = (r_state != RUN);
    assign pc_enable  = (r_state == RUN) && (r_run_mode_q || r_step_q);
    assign busy       = (r_state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE});
    assign loaded     = (r_state == RUN);
    assign err        = (r_state == ERROR);
    assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_micro_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module   : tb_micro_loader
//  Purpose  : Self-checking bench for micro_loader. Images are built from
//             random words; the expected IRAM write list is simply "word i
//             at address i" for the image that was sent.
//  Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_micro_loader;

    localparam int c_AB = 8;
    localparam int c_TO = 100;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      rx_data = '0;
    logic            rx_valid = 1'b0;
    logic            start_load = 1'b0;
    logic            run_mode = 1'b0;
    logic            step_req = 1'b0;
    logic [c_AB-1:0] iram_wa;
    logic            iram_wen;
    logic [15:0]     iram_din;
    logic            mic_rst;
    logic            pc_enable;
    logic            busy;
    logic            loaded;
    logic            err;
    logic [c_AB:0]   word_count;

    micro_loader #(
        .WIDTH          (16),
        .IRAM_ADDR_BITS (c_AB),
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .start_load (start_load),
        .run_mode   (run_mode),
        .step_req   (step_req),
        .iram_wa    (iram_wa),
        .iram_wen   (iram_wen),
        .iram_din   (iram_din),
        .mic_rst    (mic_rst),
        .pc_enable  (pc_enable),
        .busy       (busy),
        .loaded     (loaded),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          pc_cnt  = 0;
    logic [23:0] wr_q[$];
    logic [15:0] exp_words[$];

    // Observe the IRAM port and PC enable shortly after each edge.
    always @(posedge clk) begin
        #2;
        if (iram_wen) wr_q.push_back({iram_wa, iram_din});
        if (pc_enable) pc_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_wen"},   iram_wen,   0);
        chk({tag, "_wa"},    iram_wa,    0);
        chk({tag, "_din"},   iram_din,   0);
        chk({tag, "_micrst"}, mic_rst,   1);
        chk({tag, "_pcen"},  pc_enable,  0);
        chk({tag, "_busy"},  busy,       0);
        chk({tag, "_loaded"}, loaded,    0);
        chk({tag, "_err"},   err,        0);
        chk({tag, "_wc"},    word_count, 0);
    endtask

    task automatic send(input logic [7:0] b, input int gmin, input int gmax, input bit st);
        rx_data    = b;
        rx_valid   = 1'b1;
        start_load = st;
        @(negedge clk);
        rx_valid   = 1'b0;
        start_load = 1'b0;
        rx_data    = 8'($urandom);
        repeat ($urandom_range(gmax, gmin)) @(negedge clk);
    endtask

    task automatic fill_words(input int n);
        exp_words.delete();
        for (int i = 0; i < n; i++) exp_words.push_back(16'($urandom));
    endtask

    task automatic begin_load(input bit byte_with_start);
        wr_q.delete();
        start_load = 1'b1;
        rx_valid   = byte_with_start;
        rx_data    = 8'h00;
        @(negedge clk);
        start_load = 1'b0;
        rx_valid   = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_wc", word_count, 0);
        chk("start_micrst", mic_rst, 1);
        chk("start_loaded", loaded, 0);
    endtask

    task automatic load_image(input int n, input int gmin, input int gmax,
                              input bit byte_with_start, input bit start_midway);
        logic [15:0] nn;
        nn = 16'(n);
        begin_load(byte_with_start);
        send(nn[15:8], gmin, gmax, 1'b0);
        send(nn[7:0],  gmin, gmax, 1'b0);
        for (int i = 0; i < n; i++) begin
            logic [15:0] w;
            w = exp_words[i];
            send(w[15:8], gmin, gmax, start_midway && (i == 0));
            send(w[7:0],  gmin, gmax, 1'b0);
        end
    endtask

    task automatic check_load(input string tag, input int n);
        int k;
        k = 0;
        while (!(loaded || err) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_loaded"}, loaded, 1);
        chk({tag, "_err"},    err,    0);
        chk({tag, "_busy"},   busy,   0);
        chk({tag, "_micrst"}, mic_rst, 0);
        chk({tag, "_wc"},     word_count, n);
        chk({tag, "_nwr"},    wr_q.size(), n);
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            logic [7:0] a;
            a = i[7:0];
            chk({tag, "_wr"}, wr_q[i], {a, exp_words[i]});
        end
    endtask

    task automatic len_error(input string tag, input logic [15:0] n);
        begin_load(1'b0);
        send(n[15:8], 0, 0, 1'b0);
        send(n[7:0],  0, 0, 1'b0);
        chk({tag, "_err"},    err,    1);
        chk({tag, "_busy"},   busy,   0);
        chk({tag, "_loaded"}, loaded, 0);
        chk({tag, "_pcen"},   pc_enable, 0);
        for (int i = 0; i < 4; i++) send(8'($urandom), 0, 1, 1'b0);
        chk({tag, "_sticky"}, err, 1);
        chk({tag, "_nwr"},    wr_q.size(), 0);
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_reset("idle");

        // Byte coincident with start_load in IDLE must be discarded
        exp_words = {16'h5566};
        load_image(1, 0, 1, 1'b1, 1'b0);
        check_load("discard", 1);

        // Fixed image with gaps, restarted from RUN
        exp_words = {16'h1234, 16'hABCD};
        load_image(2, 1, 3, 1'b0, 1'b0);
        check_load("gaps", 2);

        // Same image back-to-back, with a start_load during the load
        load_image(2, 0, 0, 1'b0, 1'b1);
        check_load("b2b", 2);

        // Random images and gap patterns
        for (int r = 0; r < 3; r++) begin
            int n;
            n = $urandom_range(12, 1);
            fill_words(n);
            load_image(n, 0, 2, 1'b0, 1'b0);
            check_load("rand", n);
        end

        // Full-depth image streamed every cycle
        fill_words(256);
        load_image(256, 0, 0, 1'b0, 1'b0);
        check_load("full", 256);

        // Single-step then free-run
        run_mode = 1'b0;
        repeat (2) @(negedge clk);
        chk("step_idle", pc_enable, 0);
        pc_cnt = 0;
        for (int p = 0; p < 3; p++) begin
            step_req = 1'b1;
            @(negedge clk);
            step_req = 1'b0;
            chk("step_hi", pc_enable, 1);
            @(negedge clk);
            chk("step_lo", pc_enable, 0);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end
        chk("step_count", pc_cnt, 3);
        run_mode = 1'b1;
        @(negedge clk);
        chk("free_on", pc_enable, 1);
        repeat (5) @(negedge clk);
        chk("free_hold", pc_enable, 1);
        chk("free_count", pc_cnt, 9);
        run_mode = 1'b0;
        @(negedge clk);
        chk("free_off", pc_enable, 0);

        // Long but legal gaps reload the timeout
        fill_words(2);
        load_image(2, 80, 80, 1'b0, 1'b0);
        check_load("slow", 2);

        // Illegal lengths
        len_error("len0", 16'h0000);
        len_error("len257", 16'h0101);

        // Timeout in the middle of an image
        begin_load(1'b0);
        send(8'h00, 0, 0, 1'b0);
        send(8'h03, 0, 0, 1'b0);
        send(8'h11, 0, 0, 1'b0);
        send(8'h22, 0, 0, 1'b0);
        repeat (50) @(negedge clk);
        chk("to_early_err", err, 0);
        chk("to_early_busy", busy, 1);
        repeat (60) @(negedge clk);
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_nwr", wr_q.size(), 1);
        fill_words(3);
        load_image(3, 0, 1, 1'b0, 1'b0);
        check_load("to_restart", 3);

        // Reset in the middle of a load
        begin_load(1'b0);
        send(8'h00, 0, 0, 1'b0);
        send(8'h02, 0, 0, 1'b0);
        send(8'h12, 0, 0, 1'b0);
        send(8'h34, 0, 0, 1'b0);
        send(8'hAB, 0, 0, 1'b0);
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hCD;
        @(negedge clk);
        rx_valid = 1'b0;
        chk_reset("midrst");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send(8'($urandom), 0, 1, 1'b0);
        repeat (3) @(negedge clk);
        chk("midrst_nwr", wr_q.size(), 1);
        chk("midrst_wr0", wr_q[0], 24'h00_1234);
        chk("midrst_loaded", loaded, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
